ps_bc_slct_seq: RTL and testbench

PS_BC_SLCT_SEQ -- requirements
Module: ps_bc_slct_seq

---
 rtl/ps_bc_slct_if.sv | 33 +++
 rtl/ps_bc_slct_seq.sv | 136 +++++++++++++
 tb/tb_ps_bc_slct_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_bc_slct_if.sv
// Instruction flags, burst/address inputs and select outputs of the
// bus-select sequencer.
interface ps_bc_slct_if #(
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 3
);
  logic               ps_stall;
  logic               ps_imminst;
  logic               ps_popstck;
  logic               ps_pshstck;
  logic               ps_dminst;
  logic               ps_urgtrnsinst;
  logic               ps_dm_wrb;
  logic [BURST_W-1:0] ps_burst_len;
  logic [ADDR_W-1:0]  ps_ureg1_add;
  logic [ADDR_W-1:0]  ps_ureg2_add;
  logic [1:0]         ps_bc_drr_slct;
  logic [1:0]         ps_bc_di_slct;
  logic               ps_bc_busy;
  logic               ps_bc_vld;

  modport master (
    output ps_stall, ps_imminst, ps_popstck, ps_pshstck, ps_dminst,
           ps_urgtrnsinst, ps_dm_wrb, ps_burst_len, ps_ureg1_add, ps_ureg2_add,
    input  ps_bc_drr_slct, ps_bc_di_slct, ps_bc_busy, ps_bc_vld
  );

  modport slave (
    input  ps_stall, ps_imminst, ps_popstck, ps_pshstck, ps_dminst,
           ps_urgtrnsinst, ps_dm_wrb, ps_burst_len, ps_ureg1_add, ps_ureg2_add,
    output ps_bc_drr_slct, ps_bc_di_slct, ps_bc_busy, ps_bc_vld
  );
endinterface

// File: rtl/ps_bc_slct_seq.sv
// Bus-select sequencer: decodes one instruction per unstalled IDLE cycle into
// a data-register-read select (registered, latency 1) and a data-input select
// (delayed through a DI_DLY-deep shift register). Push/pop with a burst
// length above one re-issue the captured selects once per remaining word.
module ps_bc_slct_seq #(
  parameter int ADDR_W  = 8,
  parameter int DI_DLY  = 1,
  parameter int BURST_W = 3
) (
  input logic           clk,
  input logic           reset,
  ps_bc_slct_if.slave   bus
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                   r_state, w_state_nxt;
  logic [BURST_W-1:0]       r_cnt, w_cnt_nxt;
  logic [1:0]               r_drr, w_drr_nxt;
  logic                     r_vld, w_vld_nxt;
  logic                     r_busy;
  logic [DI_DLY-1:0][1:0]   r_di;
  logic [1:0]               w_di0_nxt;
  logic                     w_shift;

  logic [1:0]               w_dec_drr, w_dec_di;
  logic                     w_dec_vld, w_dec_bst;
  logic                     w_len_gt1;

  // Register-group map on the top four address bits.
  function automatic logic [1:0] grp_map(input logic [ADDR_W-1:0] a);
    logic [3:0] g;
    g = a[ADDR_W-1 -: 4];
    case (g)
      4'd0:       return 2'b10;
      4'd6, 4'd7: return 2'b01;
      4'd1, 4'd2: return 2'b00;
      default:    return 2'b11;
    endcase
  endfunction

  // A length of 0 counts as 1, so only lengths of 2 and up start a burst.
  assign w_len_gt1 = bus.ps_burst_len > BURST_W'(1);

  // Priority decode of the instruction flags; lower-priority flags are dropped.
  // In the shared DM-write/push branch a burst starts only when push is set.
  always_comb begin
    w_dec_drr = 2'b11;
    w_dec_di  = 2'b11;
    w_dec_vld = 1'b0;
    w_dec_bst = 1'b0;
    if (bus.ps_imminst) begin
      w_dec_drr = 2'b11;
      w_dec_di  = 2'b10;
      w_dec_vld = 1'b1;
    end else if (bus.ps_popstck) begin
      w_dec_drr = 2'b01;
      w_dec_di  = 2'b01;
      w_dec_vld = 1'b1;
      w_dec_bst = w_len_gt1;
    end else if (bus.ps_dminst && !bus.ps_dm_wrb) begin
      w_dec_drr = 2'b11;
      w_dec_di  = 2'b00;
      w_dec_vld = 1'b1;
    end else if (bus.ps_dminst || bus.ps_pshstck) begin
      w_dec_drr = grp_map(bus.ps_ureg1_add);
      w_dec_di  = 2'b01;
      w_dec_vld = 1'b1;
      w_dec_bst = bus.ps_pshstck && w_len_gt1;
    end else if (bus.ps_urgtrnsinst) begin
      w_dec_drr = grp_map(bus.ps_ureg2_add);
      w_dec_di  = 2'b01;
      w_dec_vld = 1'b1;
    end
  end

  // Next-state and output selection; a stall holds everything and drops vld.
  // During a burst the drr register and di stage 0 already hold the captured
  // pair, so re-issue simply reloads them.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drr_nxt   = r_drr;
    w_di0_nxt   = r_di[0];
    w_vld_nxt   = 1'b0;
    w_shift     = 1'b0;
    if (!bus.ps_stall) begin
      w_shift = 1'b1;
      case (r_state)
        S_IDLE: begin
          w_drr_nxt = w_dec_drr;
          w_di0_nxt = w_dec_di;
          w_vld_nxt = w_dec_vld;
          if (w_dec_bst) begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = bus.ps_burst_len - BURST_W'(1);
          end
        end
        S_BURST: begin
          w_vld_nxt = 1'b1;
          w_cnt_nxt = r_cnt - BURST_W'(1);
          if (r_cnt == BURST_W'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counter, select registers and the di delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_drr   <= 2'b11;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_di    <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drr   <= w_drr_nxt;
      r_vld   <= w_vld_nxt;
      r_busy  <= (w_state_nxt == S_BURST);
      if (w_shift) begin
        r_di[0] <= w_di0_nxt;
        for (int i = 1; i < DI_DLY; i++) r_di[i] <= r_di[i-1];
      end
    end
  end

  assign bus.ps_bc_drr_slct = r_drr;
  assign bus.ps_bc_di_slct  = r_di[DI_DLY-1];
  assign bus.ps_bc_busy     = r_busy;
  assign bus.ps_bc_vld      = r_vld;

endmodule

// File: tb/tb_ps_bc_slct_seq.sv
// Bench for ps_bc_slct_seq: two instances (DI_DLY 1 and 3) share one stimulus
// stream and are compared every cycle against a word-count reference model.
module tb_ps_bc_slct_seq;

  logic       clk = 1'b0;
  logic       reset, stall, imm, pop, psh, dm, urg, wrb;
  logic [2:0] len;
  logic [7:0] u1, u2;

  ps_bc_slct_if #(.ADDR_W(8), .BURST_W(3)) if1 ();
  ps_bc_slct_if #(.ADDR_W(8), .BURST_W(3)) if3 ();

  assign if1.ps_stall = stall;  assign if3.ps_stall = stall;
  assign if1.ps_imminst = imm;  assign if3.ps_imminst = imm;
  assign if1.ps_popstck = pop;  assign if3.ps_popstck = pop;
  assign if1.ps_pshstck = psh;  assign if3.ps_pshstck = psh;
  assign if1.ps_dminst = dm;    assign if3.ps_dminst = dm;
  assign if1.ps_urgtrnsinst = urg; assign if3.ps_urgtrnsinst = urg;
  assign if1.ps_dm_wrb = wrb;   assign if3.ps_dm_wrb = wrb;
  assign if1.ps_burst_len = len; assign if3.ps_burst_len = len;
  assign if1.ps_ureg1_add = u1; assign if3.ps_ureg1_add = u1;
  assign if1.ps_ureg2_add = u2; assign if3.ps_ureg2_add = u2;

  ps_bc_slct_seq #(.ADDR_W(8), .DI_DLY(1), .BURST_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  ps_bc_slct_seq #(.ADDR_W(8), .DI_DLY(3), .BURST_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words still to re-issue, last issued pair, and the
  // history of di values issued (newest first) for any delay depth.
  int         m_rem;
  logic [1:0] m_drr, m_cap_di;
  logic       m_vld;
  logic [1:0] hist[$];

  function automatic logic [1:0] gmap(input logic [7:0] a);
    int g;
    g = int'(a) / 16;
    if (g == 0) return 2'b10;
    if (g == 6 || g == 7) return 2'b01;
    if (g == 1 || g == 2) return 2'b00;
    return 2'b11;
  endfunction

  task automatic model_edge();
    logic [1:0] d, i;
    logic       v;
    int         words, eff;
    if (reset) begin
      m_rem = 0; m_drr = 2'b11; m_vld = 1'b0; m_cap_di = 2'b11;
      hist = {2'b11, 2'b11, 2'b11};
    end else if (stall) begin
      m_vld = 1'b0;
    end else if (m_rem > 0) begin
      m_vld = 1'b1;
      hist.push_front(m_cap_di);
      m_rem--;
    end else begin
      eff = (len == 3'd0) ? 1 : int'(len);
      words = 1;
      if (imm)             begin d = 2'b11;    i = 2'b10; v = 1'b1; end
      else if (pop)        begin d = 2'b01;    i = 2'b01; v = 1'b1; words = eff; end
      else if (dm && !wrb) begin d = 2'b11;    i = 2'b00; v = 1'b1; end
      else if (dm || psh)  begin d = gmap(u1); i = 2'b01; v = 1'b1; words = psh ? eff : 1; end
      else if (urg)        begin d = gmap(u2); i = 2'b01; v = 1'b1; end
      else                 begin d = 2'b11;    i = 2'b11; v = 1'b0; end
      m_drr = d; m_vld = v; m_cap_di = i;
      hist.push_front(i);
      m_rem = words - 1;
    end
    while (hist.size() > 3) void'(hist.pop_back());
  endtask

  // One clock: advance the model on the inputs present at the edge, then
  // compare both instances after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("drr1", {6'd0, if1.ps_bc_drr_slct}, {6'd0, m_drr});
    chk("drr3", {6'd0, if3.ps_bc_drr_slct}, {6'd0, m_drr});
    chk("vld",  {7'd0, if1.ps_bc_vld},  {7'd0, m_vld});
    chk("vld3", {7'd0, if3.ps_bc_vld},  {7'd0, m_vld});
    chk("busy", {7'd0, if1.ps_bc_busy}, {7'd0, m_rem > 0});
    chk("di1",  {6'd0, if1.ps_bc_di_slct}, {6'd0, hist[0]});
    chk("di3",  {6'd0, if3.ps_bc_di_slct}, {6'd0, hist[2]});
  endtask

  task automatic idle_in();
    {imm, pop, psh, dm, urg, wrb} = 6'b0;
    len = 3'd1; u1 = 8'h00; u2 = 8'h00; stall = 1'b0;
  endtask

  typedef struct packed {
    logic [5:0] fl;   // {imm, pop, psh, dm, urg, wrb}
    logic [2:0] len;
    logic [7:0] u1, u2;
    logic [1:0] drr, di;
    logic       vld;
  } vec_t;

  vec_t tv[13];
  int   pulses;

  initial begin
    tv[0]  = '{6'b100000, 3'd1, 8'h00, 8'h00, 2'b11, 2'b10, 1'b1}; // imm
    tv[1]  = '{6'b110000, 3'd1, 8'h00, 8'h00, 2'b11, 2'b10, 1'b1}; // imm beats pop
    tv[2]  = '{6'b010000, 3'd1, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1}; // pop single
    tv[3]  = '{6'b000100, 3'd1, 8'h65, 8'h00, 2'b11, 2'b00, 1'b1}; // dm read
    tv[4]  = '{6'b000101, 3'd1, 8'h65, 8'h00, 2'b01, 2'b01, 1'b1}; // dm write grp6
    tv[5]  = '{6'b001000, 3'd1, 8'h0A, 8'h00, 2'b10, 2'b01, 1'b1}; // push grp0
    tv[6]  = '{6'b001000, 3'd1, 8'h25, 8'h00, 2'b00, 2'b01, 1'b1}; // push grp2
    tv[7]  = '{6'b000010, 3'd1, 8'h00, 8'h70, 2'b01, 2'b01, 1'b1}; // urg grp7
    tv[8]  = '{6'b000010, 3'd1, 8'h00, 8'hF3, 2'b11, 2'b01, 1'b1}; // urg grp15
    tv[9]  = '{6'b000000, 3'd1, 8'h00, 8'h00, 2'b11, 2'b11, 1'b0}; // none
    tv[10] = '{6'b001100, 3'd1, 8'h12, 8'h00, 2'b11, 2'b00, 1'b1}; // dm read beats push
    tv[11] = '{6'b001010, 3'd1, 8'h12, 8'h65, 2'b00, 2'b01, 1'b1}; // push beats urg
    tv[12] = '{6'b000001, 3'd1, 8'h65, 8'h00, 2'b11, 2'b11, 1'b0}; // wrb alone = none

    idle_in();
    reset = 1'b1;
    step(); step();
    chk("rst_drr",  {6'd0, if1.ps_bc_drr_slct}, 8'h03);
    chk("rst_di3",  {6'd0, if3.ps_bc_di_slct},  8'h03);
    chk("rst_busy", {7'd0, if1.ps_bc_busy},     8'h00);
    chk("rst_vld",  {7'd0, if1.ps_bc_vld},      8'h00);
    reset = 1'b0;
    step();

    // DM write, group 6.
    dm = 1'b1; wrb = 1'b1; u1 = 8'h65;
    step();
    chk("dmw_drr", {6'd0, if1.ps_bc_drr_slct}, 8'h01);
    chk("dmw_vld", {7'd0, if1.ps_bc_vld},      8'h01);
    chk("dmw_di1", {6'd0, if1.ps_bc_di_slct},  8'h01);
    chk("dmw_di3_early", {6'd0, if3.ps_bc_di_slct}, 8'h03);
    idle_in();
    step(); step();
    chk("dmw_di3", {6'd0, if3.ps_bc_di_slct}, 8'h01);
    step(); step();

    // Single-word decode table.
    foreach (tv[k]) begin
      {imm, pop, psh, dm, urg, wrb} = tv[k].fl;
      len = tv[k].len; u1 = tv[k].u1; u2 = tv[k].u2;
      step();
      chk($sformatf("tv%0d_drr", k), {6'd0, if1.ps_bc_drr_slct}, {6'd0, tv[k].drr});
      chk($sformatf("tv%0d_di",  k), {6'd0, if1.ps_bc_di_slct},  {6'd0, tv[k].di});
      chk($sformatf("tv%0d_vld", k), {7'd0, if1.ps_bc_vld},      {7'd0, tv[k].vld});
      chk($sformatf("tv%0d_busy", k), {7'd0, if1.ps_bc_busy},    8'h00);
      idle_in();
      step();
    end

    // Push burst of 3, urgtrns raised mid-burst must be ignored.
    psh = 1'b1; len = 3'd3; u1 = 8'h12;
    step();
    chk("b3_w1_drr", {6'd0, if1.ps_bc_drr_slct}, 8'h00);
    chk("b3_w1_busy", {7'd0, if1.ps_bc_busy}, 8'h01);
    idle_in(); urg = 1'b1; u2 = 8'h65;
    step();
    chk("b3_w2_drr", {6'd0, if1.ps_bc_drr_slct}, 8'h00);
    chk("b3_w2_vld", {7'd0, if1.ps_bc_vld}, 8'h01);
    chk("b3_w2_busy", {7'd0, if1.ps_bc_busy}, 8'h01);
    step();
    chk("b3_w3_vld", {7'd0, if1.ps_bc_vld}, 8'h01);
    chk("b3_w3_busy", {7'd0, if1.ps_bc_busy}, 8'h00);
    idle_in();
    step();
    chk("b3_end_vld", {7'd0, if1.ps_bc_vld}, 8'h00);

    // Pop burst of 2 with a two-cycle stall after the first word.
    pulses = 0;
    pop = 1'b1; len = 3'd2;
    step(); pulses += int'(if1.ps_bc_vld);
    idle_in(); stall = 1'b1;
    step(); pulses += int'(if1.ps_bc_vld);
    chk("pst_busy", {7'd0, if1.ps_bc_busy}, 8'h01);
    step(); pulses += int'(if1.ps_bc_vld);
    stall = 1'b0;
    step(); pulses += int'(if1.ps_bc_vld);
    chk("pst_w2_drr", {6'd0, if1.ps_bc_drr_slct}, 8'h01);
    step(); pulses += int'(if1.ps_bc_vld);
    step(); pulses += int'(if1.ps_bc_vld);
    chk("pst_pulses", 8'(pulses), 8'd2);

    // Reset mid-burst aborts it.
    psh = 1'b1; len = 3'd5; u1 = 8'h0A;
    step();
    idle_in();
    step();
    reset = 1'b1;
    step();
    chk("rab_drr",  {6'd0, if1.ps_bc_drr_slct}, 8'h03);
    chk("rab_di",   {6'd0, if1.ps_bc_di_slct},  8'h03);
    chk("rab_busy", {7'd0, if1.ps_bc_busy},     8'h00);
    chk("rab_vld",  {7'd0, if1.ps_bc_vld},      8'h00);
    reset = 1'b0;
    step();
    chk("rab_norei", {7'd0, if1.ps_bc_vld}, 8'h00);

    // Length 0 push is one word; urgtrns di through the 3-deep delay.
    psh = 1'b1; len = 3'd0; u1 = 8'h12;
    step();
    chk("l0_busy", {7'd0, if1.ps_bc_busy}, 8'h00);
    idle_in();
    step();
    chk("l0_vld", {7'd0, if1.ps_bc_vld}, 8'h00);
    step(); step();
    urg = 1'b1; u2 = 8'h40;
    step();
    chk("u40_drr", {6'd0, if3.ps_bc_drr_slct}, 8'h03);
    idle_in();
    step();
    chk("u40_di3_c2", {6'd0, if3.ps_bc_di_slct}, 8'h03);
    step();
    chk("u40_di3_c3", {6'd0, if3.ps_bc_di_slct}, 8'h01);

    // Maximum burst of 7 words.
    pulses = 0;
    psh = 1'b1; len = 3'd7; u1 = 8'h70;
    step(); pulses += int'(if1.ps_bc_vld);
    idle_in();
    for (int c = 0; c < 8; c++) begin step(); pulses += int'(if1.ps_bc_vld); end
    chk("max_pulses", 8'(pulses), 8'd7);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      imm   = ($urandom_range(0, 7) == 0);
      pop   = ($urandom_range(0, 5) == 0);
      psh   = ($urandom_range(0, 4) == 0);
      dm    = ($urandom_range(0, 4) == 0);
      urg   = ($urandom_range(0, 3) == 0);
      wrb   = ($urandom_range(0, 1) == 0);
      len   = 3'($urandom_range(0, 7));
      u1    = 8'($urandom_range(0, 255));
      u2    = 8'($urandom_range(0, 255));
      step();
    end
    reset = 1'b0;
    idle_in();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
